data_memory_master: RTL and testbench

Bus initiator that drives the `DataMemory` port (`address`, `write`, `data_inputs`, `data_outputs`) on behalf of the microprocessor datapath. It accepts single or burst load/store requests over a valid/ready handshake and sequences per-beat memory accesses with auto-incrementing addresses. Write data is consumed per beat. Read data is returned with a one-cycle `rd_valid` strobe. It sits between the CPU load/store path and `DataMemory`, and is the only agent driving the memory port.

---
 rtl/data_memory_master.sv | 142 ++++++++++++++
 tb/tb_data_memory_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_master.sv
// Bus initiator for the DataMemory port: single/burst loads and stores with auto-incrementing addresses.
// Optional store read-back verification is enabled by defining DATA_MEMORY_MASTER_VERIFY_EN.
module data_memory_master #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  // Request channel: a request transfers on a cycle where req_valid and req_ready are both 1.
  // Store data: a beat transfers on a cycle where wr_valid and wr_ready are both 1.
  // Load data: rd_valid is a one-cycle strobe with no backpressure.
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  verify_error,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] data_inputs,
  input  logic [DATA_WIDTH-1:0] data_outputs,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RD     = 3'd2,
    ST_DONE   = 3'd3
`ifdef DATA_MEMORY_MASTER_VERIFY_EN
    , ST_VERIFY = 3'd4
`endif
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [3:0]            beat_cnt;
  logic [1:0]            lat_cnt;
  logic                  accept;

  // Handshake qualifiers are gated by reset so nothing transfers while reset is held.
  assign req_ready   = (state == ST_IDLE) && !reset;
  assign wr_ready    = (state == ST_WR) && !reset;
  assign accept      = req_valid && req_ready;
  assign write       = wr_ready && wr_valid;
  assign address     = cur_addr;
  assign data_inputs = write ? wr_data : '0;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign dbg_state   = state;

`ifdef DATA_MEMORY_MASTER_VERIFY_EN
  logic [DATA_WIDTH-1:0] wr_hold;
  logic                  verify_error_q;
  assign verify_error = verify_error_q;
`else
  assign verify_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cur_addr <= '0;
      beat_cnt <= '0;
      lat_cnt  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
`ifdef DATA_MEMORY_MASTER_VERIFY_EN
      wr_hold        <= '0;
      verify_error_q <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur_addr <= req_addr;
            beat_cnt <= req_len;
            lat_cnt  <= '0;
            state    <= req_write ? ST_WR : ST_RD;
`ifdef DATA_MEMORY_MASTER_VERIFY_EN
            verify_error_q <= 1'b0;
`endif
          end
        end
        ST_WR: begin
          if (write) begin
`ifdef DATA_MEMORY_MASTER_VERIFY_EN
            // Hold the address; it advances only after the read-back compare.
            wr_hold <= wr_data;
            lat_cnt <= '0;
            state   <= ST_VERIFY;
`else
            cur_addr <= cur_addr + ADDR_WIDTH'(1);
            beat_cnt <= beat_cnt - 4'd1;
            if (beat_cnt == 4'd0) state <= ST_DONE;
`endif
          end
        end
        ST_RD: begin
          // Address is held until its data has had READ_LATENCY cycles to appear.
          if (lat_cnt == LAT_LAST) begin
            rd_data  <= data_outputs;
            rd_valid <= 1'b1;
            lat_cnt  <= '0;
            cur_addr <= cur_addr + ADDR_WIDTH'(1);
            beat_cnt <= beat_cnt - 4'd1;
            if (beat_cnt == 4'd0) state <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
`ifdef DATA_MEMORY_MASTER_VERIFY_EN
        ST_VERIFY: begin
          if (lat_cnt == LAT_LAST) begin
            if (data_outputs != wr_hold) verify_error_q <= 1'b1;
            lat_cnt  <= '0;
            cur_addr <= cur_addr + ADDR_WIDTH'(1);
            beat_cnt <= beat_cnt - 4'd1;
            state    <= (beat_cnt == 4'd0) ? ST_DONE : ST_WR;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_master.sv
// Self-checking bench for data_memory_master: directed vector table, hand-written corner sequences,
// and randomized bursts against a behavioural memory/timing reference model.
module tb_data_memory_master;

  localparam int RL = 1;
`ifdef DATA_MEMORY_MASTER_VERIFY_EN
  localparam int VGAP = RL + 1;
  localparam logic VERIFY_ON = 1'b1;
`else
  localparam int VGAP = 0;
  localparam logic VERIFY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, req_write = 1'b0;
  logic [7:0] req_addr = '0;
  logic [3:0] req_len = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       req_ready, wr_ready, rd_valid, busy, done, verify_error, write;
  logic [7:0] rd_data, address, data_inputs, data_outputs;
  logic [2:0] dbg_state;

  data_memory_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
    .verify_error(verify_error), .address(address), .write(write),
    .data_inputs(data_inputs), .data_outputs(data_outputs), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  logic mem_init = 1'b1;
  logic corrupt_en = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] rd_pipe;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read memory (one cycle of read latency); optional corruption of address 0x10.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (write) begin
      mem[address] <= (corrupt_en && address == 8'h10) ? ~data_inputs : data_inputs;
    end
    rd_pipe <= mem[address];
  end
  assign data_outputs = rd_pipe;

  // ---------------- monitor ----------------
  logic [7:0] wa_q[$], wd_q[$], rd_q[$];
  int         wc_q[$], rc_q[$], dc_q[$], ac_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (write) begin wa_q.push_back(address); wd_q.push_back(data_inputs); wc_q.push_back(cyc); end
      if (rd_valid) begin rd_q.push_back(rd_data); rc_q.push_back(cyc); end
      if (done) dc_q.push_back(cyc);
      if (req_valid && req_ready) ac_q.push_back(cyc);
    end
  end

  // ---------------- scoreboard ----------------
  int         checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ref_mem [256];
  logic [7:0] wdata_q[$];
  int         acc_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out (t=%0t)", name, $time);
  endtask

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_logs();
    wa_q = {}; wd_q = {}; wc_q = {}; rd_q = {}; rc_q = {}; dc_q = {}; ac_q = {};
  endtask

  task automatic wait_accept();
    bit got = 0;
    int guard = 0;
    while (!got && guard < 400) begin
      @(negedge clk);
      if (req_ready && req_valid) begin got = 1; acc_cyc = cyc; end
      @(posedge clk); #1;
      guard++;
    end
    if (!got) timeout("req_accept");
  endtask

  task automatic wait_done(input int n);
    int guard = 0;
    while (dc_q.size() < n && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    if (dc_q.size() < n) timeout("done_wait");
  endtask

  task automatic feed_beats(input logic [3:0] len, input int sb, input int sc);
    bit took;
    int guard;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == sb) begin
        wr_valid = 1'b0;
        repeat (sc) begin @(posedge clk); #1; end
      end
      wr_valid = 1'b1;
      wr_data  = wdata_q[b];
      took = 0;
      guard = 0;
      while (!took && guard < 64) begin
        @(negedge clk); took = wr_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!took) begin timeout("store_beat"); break; end
    end
    wr_valid = 1'b0;
    wr_data  = '0;
  endtask

  task automatic run_store(input logic [7:0] a, input logic [3:0] len, input int sb, input int sc,
                           input bit hold_next);
    int last;
    clear_logs();
    req_write = 1'b1; req_addr = a; req_len = len; req_valid = 1'b1;
    wait_accept();
    if (hold_next) begin req_write = 1'b0; req_addr = 8'h40; req_len = 4'd0; end
    else req_valid = 1'b0;
    feed_beats(len, sb, sc);
    wait_done(1);
    check("st_count", wa_q.size(), int'(len) + 1);
    check("st_done_cnt", dc_q.size(), 1);
    for (int b = 0; b <= int'(len); b++) begin
      automatic logic [7:0] ea = a + 8'(b);
      if (b < wa_q.size()) begin
        check("st_addr", wa_q[b], ea);
        check("st_data", wd_q[b], wdata_q[b]);
        if (b == 0) check("st_first_lat", wc_q[0], acc_cyc + 1 + ((sb == 0) ? sc : 0));
        else check("st_gap", wc_q[b] - wc_q[b-1], 1 + imax((b == sb) ? sc : 0, VGAP));
      end
      ref_mem[ea] = (corrupt_en && ea == 8'h10) ? ~wdata_q[b] : wdata_q[b];
    end
    last = wc_q.size() - 1;
    if (last >= 0 && dc_q.size() > 0) check("st_done_lat", dc_q[0], wc_q[last] + 1 + VGAP);
  endtask

  task automatic run_load(input logic [7:0] a, input logic [3:0] len);
    logic [7:0] ed;
    clear_logs();
    exp_q = {};
    for (int b = 0; b <= int'(len); b++) exp_q.push_back(ref_mem[a + 8'(b)]);
    req_write = 1'b0; req_addr = a; req_len = len; req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0;
    check("ld_verr_clear", verify_error, 0);
    wait_done(1);
    check("ld_count", rd_q.size(), int'(len) + 1);
    for (int b = 0; b <= int'(len); b++) begin
      ed = exp_q.pop_front();
      if (b < rd_q.size()) begin
        check("ld_data", rd_q[b], ed);
        if (b == 0) check("ld_first_lat", rc_q[0], acc_cyc + 2 + RL);
        else check("ld_gap", rc_q[b] - rc_q[b-1], RL + 1);
      end
    end
    if (rc_q.size() > 0 && dc_q.size() > 0) check("ld_done_with_last", dc_q[0], rc_q[rc_q.size()-1]);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic            is_wr;
    logic [7:0]      addr;
    logic [3:0]      len;
    logic [3:0][7:0] din;
    logic [4:0]      stall_beat;
    logic [3:0]      stall_cyc;
    logic [3:0][7:0] exp_addr;
    logic [3:0][7:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [7:0] a, input logic [3:0] l,
                              input logic [31:0] din, input logic [4:0] sb, input logic [3:0] sc,
                              input logic [31:0] ea, input logic [31:0] ed);
    vec_t v;
    v.is_wr = w; v.addr = a; v.len = l; v.din = din; v.stall_beat = sb; v.stall_cyc = sc;
    v.exp_addr = ea; v.exp_data = ed;
    return v;
  endfunction

  vec_t vecs[6];

  // ---------------- main test ----------------
  initial begin
    automatic int mism;
    automatic logic [7:0] a;
    automatic logic [3:0] l;
    automatic int sb, sc;

    vecs[0] = mk(1, 8'h02, 0, 32'h00000055, 31, 0, 32'h00000002, 32'h00000055);
    vecs[1] = mk(1, 8'h0A, 0, 32'h000000CC, 31, 0, 32'h0000000A, 32'h000000CC);
    vecs[2] = mk(0, 8'h02, 0, 32'h0,        31, 0, 32'h00000002, 32'h00000055);
    vecs[3] = mk(0, 8'h0A, 0, 32'h0,        31, 0, 32'h0000000A, 32'h000000CC);
    vecs[4] = mk(1, 8'hFE, 3, 32'h44332211, 2,  2, 32'h0100FFFE, 32'h44332211);
    vecs[5] = mk(0, 8'hFE, 3, 32'h0,        31, 0, 32'h0100FFFE, 32'h44332211);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);

    // Reset state
    repeat (3) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check("rst_req_ready_in_reset", req_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", write, 0);
    check("rst_address", address, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_verify_error", verify_error, 0);
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_wr) begin
        wdata_q = {};
        for (int b = 0; b <= int'(vecs[i].len); b++) wdata_q.push_back(vecs[i].din[b]);
        run_store(vecs[i].addr, vecs[i].len, int'(vecs[i].stall_beat), int'(vecs[i].stall_cyc), 0);
        for (int b = 0; b <= int'(vecs[i].len); b++)
          if (b < wa_q.size()) begin
            check("vec_wr_addr", wa_q[b], vecs[i].exp_addr[b]);
            check("vec_wr_data", wd_q[b], vecs[i].exp_data[b]);
          end
      end else begin
        run_load(vecs[i].addr, vecs[i].len);
        for (int b = 0; b <= int'(vecs[i].len); b++)
          if (b < rd_q.size()) check("vec_rd_data", rd_q[b], vecs[i].exp_data[b]);
      end
    end

    // Request held during an active burst is taken once, the cycle after done
    wdata_q = {8'h5A, 8'h6B, 8'h7C, 8'h8D};
    run_store(8'h30, 3, -1, 0, 1);
    check("busy_acc_during_burst", ac_q.size(), 1);
    for (int g = 0; g < 20 && ac_q.size() < 2; g++) begin @(posedge clk); #1; end
    req_valid = 1'b0;
    if (ac_q.size() >= 2 && dc_q.size() >= 1) check("busy_acc_cycle", ac_q[1], dc_q[0] + 1);
    else timeout("busy_second_accept");
    wait_done(2);
    repeat (5) begin @(posedge clk); #1; end
    check("busy_accepts", ac_q.size(), 2);
    check("busy_rd_count", rd_q.size(), 1);
    if (rd_q.size() > 0) check("busy_rd_data", rd_q[0], ref_mem[8'h40]);

    // Read-back verification with a corrupting memory location
    corrupt_en = 1'b1;
    wdata_q = {8'hA1, 8'hB2, 8'hC3};
    run_store(8'h0F, 2, -1, 0, 0);
    corrupt_en = 1'b0;
    check("verify_err_set", verify_error, VERIFY_ON);
    run_load(8'h0F, 2);

    // Randomized bursts against the reference model
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom_range(0, 255));
      l = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        wdata_q = {};
        for (int b = 0; b <= int'(l); b++) wdata_q.push_back(8'($urandom));
        sb = $urandom_range(0, int'(l) + 3);
        sc = $urandom_range(0, 3);
        run_store(a, l, sb, sc, 0);
      end else begin
        run_load(a, l);
      end
    end

    // Reset in the middle of a 16-beat store
    wdata_q = {};
    for (int b = 0; b < 16; b++) wdata_q.push_back(8'($urandom));
    clear_logs();
    req_write = 1'b1; req_addr = 8'h80; req_len = 4'd15; req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0;
    feed_beats(4, -1, 0);
    for (int b = 0; b < 5; b++) ref_mem[8'h80 + 8'(b)] = wdata_q[b];
    wr_valid = 1'b1; wr_data = wdata_q[5]; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_write", write, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_address", address, 0);
    check("mid_rst_data_inputs", data_inputs, 0);
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_wr_ready", wr_ready, 0);
    check("mid_rst_verify_error", verify_error, 0);
    check("mid_rst_req_ready", req_ready, 1);
    @(posedge clk); #1 wr_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("mid_rst_no_done", dc_q.size(), 0);
    check("mid_rst_beats", wa_q.size(), 5);
    mism = 0;
    for (int b = 0; b < 16; b++) if (mem[8'h80 + 8'(b)] !== ref_mem[8'h80 + 8'(b)]) mism++;
    check("mid_rst_mem", mism, 0);
    run_load(8'h80, 4'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
